instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction decoder: owns the PC, issues word reads to instruction memory and presents each fetched instruction with its PC through a one-entry valid/ready output slot.
- The execute stage redirects the PC for taken branches, jal and jalr.
- In-flight fetches that a redirect makes stale are drained and discarded, never forwarded.

---
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues word reads to instruction memory and hands
// each fetched instruction plus its PC to the decoder through a one-entry slot.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_ren_I,
  output logic [31:0] mem_addr_I,
  input  logic        mem_stall_I,
  input  logic [31:0] mem_rdata_I,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DROP  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        ren_s;
  logic        complete_s;
  logic        accept_s;
  logic [31:0] target_s;

  // Request generation; a stalled request keeps its address because the slot
  // stays empty and the PC cannot advance until the request completes.
  always_comb begin
    ren_s      = 1'b0;
    mem_addr_I = pc_q;
    case (state_q)
      S_FETCH: ren_s = !valid_q || instr_ready;
      S_DROP: begin
        ren_s      = 1'b1;
        mem_addr_I = drop_addr_q;
      end
      default: ren_s = 1'b0;
    endcase
  end

  assign mem_ren_I  = ren_s & ~rst;
  assign complete_s = mem_ren_I & ~mem_stall_I;
  assign accept_s   = valid_q & instr_ready;
  assign target_s   = redirect_pc & 32'hFFFF_FFFC;

  // Next-state: redirect flushes the slot and overrides any completion or accept.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc_out_d    = pc_out_q;
    if (redirect_valid) begin
      pc_d    = target_s;
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      case (state_q)
        S_IDLE:  state_d = S_FETCH;
        S_FETCH: begin
          if (mem_ren_I && mem_stall_I) begin
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_DROP:  state_d = mem_stall_I ? S_DROP : S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FETCH;
        S_FETCH: begin
          if (complete_s) begin
            instr_d  = mem_rdata_I;
            pc_out_d = pc_q;
            valid_d  = 1'b1;
            pc_d     = pc_q + 32'd4;
          end else if (accept_s) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
          end else begin
            valid_d = valid_q;
          end
        end
        S_DROP:  state_d = mem_stall_I ? S_DROP : S_FETCH;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= 32'h0000_0000;
      valid_q     <= 1'b0;
      instr_q     <= NOP_INSTR;
      pc_out_q    <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc_out_q    <= pc_out_d;
    end
  end

  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: inputs change on the falling edge and
// everything is checked 1 time unit later; memory data is the address tagged.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic        mem_stall;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TAG = 32'h5A5A_0000;

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr ^ TAG;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .mem_ren_I      (mem_ren),
    .mem_addr_I     (mem_addr),
    .mem_stall_I    (mem_stall),
    .mem_rdata_I    (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .pc_out         (pc_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Fetching with a delivered slot: request at addr, slot holds pc p.
  task automatic chk_flow(input string tag, input logic [31:0] p, input logic [31:0] addr);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({tag, "_pc"}, pc_out, p);
    chk({tag, "_instr"}, instr_out, p ^ TAG);
    chk({tag, "_ren"}, {31'd0, mem_ren}, 32'd1);
    chk({tag, "_addr"}, mem_addr, addr);
  endtask

  // Empty slot with a request at addr.
  task automatic chk_empty(input string tag, input logic [31:0] addr);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_instr"}, instr_out, NOP);
    chk({tag, "_ren"}, {31'd0, mem_ren}, 32'd1);
    chk({tag, "_addr"}, mem_addr, addr);
  endtask

  initial begin
    rst = 1'b1; mem_stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; instr_ready = 1'b1;

    // Reset
    @(negedge clk); #1;
    chk("rst_ren", {31'd0, mem_ren}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr_out, NOP);
    chk("rst_pc", pc_out, 32'h0);
    chk("idle_ren", {31'd0, mem_ren}, 32'd0);

    // Streaming fetch
    @(negedge clk); #1;
    chk("first_ren", {31'd0, mem_ren}, 32'd1);
    chk("first_addr", mem_addr, 32'h0);
    chk("first_valid", {31'd0, instr_valid}, 32'd0);
    @(negedge clk); #1; chk_flow("s0", 32'h0, 32'h4);
    @(negedge clk); #1; chk_flow("s1", 32'h4, 32'h8);

    // Backpressure for 3 cycles
    @(negedge clk); instr_ready = 1'b0; #1;
    chk("bp0_ren", {31'd0, mem_ren}, 32'd0);
    chk("bp0_pc", pc_out, 32'h8);
    @(negedge clk); #1;
    chk("bp1_ren", {31'd0, mem_ren}, 32'd0);
    chk("bp1_pc", pc_out, 32'h8);
    @(negedge clk); #1;
    chk("bp2_ren", {31'd0, mem_ren}, 32'd0);
    chk("bp2_instr", instr_out, 32'h8 ^ TAG);
    @(negedge clk); instr_ready = 1'b1; #1;
    chk_flow("bp_rel", 32'h8, 32'hC);

    // Stall for 4 cycles on 0x10
    @(negedge clk); mem_stall = 1'b1; #1;
    chk_flow("st0", 32'hC, 32'h10);
    @(negedge clk); #1; chk_empty("st1", 32'h10);
    @(negedge clk); #1; chk_empty("st2", 32'h10);
    @(negedge clk); #1; chk_empty("st3", 32'h10);
    @(negedge clk); mem_stall = 1'b0; #1;
    chk_empty("st4", 32'h10);
    @(negedge clk); #1; chk_flow("st_done", 32'h10, 32'h14);
    @(negedge clk); #1; chk_flow("s14", 32'h14, 32'h18);
    @(negedge clk); #1; chk_flow("s18", 32'h18, 32'h1C);

    // Redirect to 0x203 while 0x20 stalls, then 0x300 during DROP
    @(negedge clk); mem_stall = 1'b1; #1;
    chk_flow("s1c", 32'h1C, 32'h20);
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_0203; #1;
    chk_empty("rd_pre", 32'h20);
    @(negedge clk); redirect_pc = 32'h0000_0300; #1;
    chk_empty("drop0", 32'h20);
    @(negedge clk); redirect_valid = 1'b0; mem_stall = 1'b0; #1;
    chk_empty("drop1", 32'h20);
    @(negedge clk); #1; chk_empty("drop_done", 32'h300);
    @(negedge clk); #1; chk_flow("rd_first", 32'h300, 32'h304);

    // Redirect to 0x3C with nothing in flight
    instr_ready = 1'b0;
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 32'h0000_003C; #1;
    chk("hold_ren", {31'd0, mem_ren}, 32'd0);
    @(negedge clk); redirect_valid = 1'b0; instr_ready = 1'b1; #1;
    chk_empty("rd3c", 32'h3C);
    @(negedge clk); #1; chk_flow("s3c", 32'h3C, 32'h40);

    // Redirect coinciding with completion of 0x40 and accept of 0x3C
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1000;
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk_empty("flush", 32'h1000);
    @(negedge clk); #1; chk_flow("s1000", 32'h1000, 32'h1004);

    // Reset mid-stall at 0x80
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0080;
    @(negedge clk); redirect_valid = 1'b0; mem_stall = 1'b1; #1;
    chk_empty("st80", 32'h80);
    @(negedge clk); rst = 1'b1; #1;
    chk("rst_mid_ren", {31'd0, mem_ren}, 32'd0);
    @(negedge clk); rst = 1'b0; mem_stall = 1'b0; #1;
    chk("rst2_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst2_pc", pc_out, 32'h0);
    chk("rst2_instr", instr_out, NOP);
    @(negedge clk); #1; chk_empty("rst2_fetch", 32'h0);
    @(negedge clk); #1; chk_flow("rst2_s0", 32'h0, 32'h4);

    // PC wrap-around
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    @(negedge clk); redirect_valid = 1'b0; #1;
    chk_empty("wrap_req", 32'hFFFF_FFFC);
    @(negedge clk); #1; chk_flow("wrap_top", 32'hFFFF_FFFC, 32'h0);
    @(negedge clk); #1; chk_flow("wrap_zero", 32'h0, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
